// File: rtl/tournament_pkg.sv
// Shared types, constants and counter arithmetic for the tournament chooser.
package tournament_pkg;

    typedef logic [1:0] chooser_ctr_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } chooser_state_e;

    localparam chooser_ctr_t CHOOSE_GLOBAL_MIN = 2'b10;
    localparam chooser_ctr_t CTR_INIT          = 2'b01;
    localparam chooser_ctr_t CTR_MAX           = 2'b11;
    localparam chooser_ctr_t CTR_MIN           = 2'b00;

    // Move toward whichever predictor alone was right; saturate, never wrap.
    function automatic chooser_ctr_t sat_update(input chooser_ctr_t ctr,
                                                input logic         g_ok,
                                                input logic         l_ok);
        chooser_ctr_t res;
        res = ctr;
        if (g_ok && !l_ok && (ctr != CTR_MAX)) begin
            res = ctr + 2'd1;
        end else if (!g_ok && l_ok && (ctr != CTR_MIN)) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of 2-bit chooser counters with one lookup read port and one update
// port. The update port either forces the init value or applies a saturating
// step to the addressed entry; a lookup to the entry being updated in the same
// cycle sees the new value (write-first).
module sat_counter_table
    import tournament_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             init_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic             g_ok_i,
    input  logic             l_ok_i,
    input  logic [IDX_W-1:0] raddr_i,
    output chooser_ctr_t     rdata_o
);

    localparam int DEPTH = 1 << IDX_W;

    chooser_ctr_t mem [DEPTH];
    chooser_ctr_t wdata;

    // Compute the value being written and forward it to a colliding lookup.
    always_comb begin
        wdata   = init_i ? CTR_INIT : sat_update(mem[waddr_i], g_ok_i, l_ok_i);
        rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata : mem[raddr_i];
    end

    // Storage has no reset; the init sequencer in the parent clears it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata;
        end
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser: PC^GHR indexed table of 2-bit counters that picks the
// global (counter >= 2'b10) or local predictor, trained at branch resolution.
// After reset an init sequencer walks the table writing weakly-local values.
module tournament_chooser
    import tournament_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 8,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready_o,
    input  logic             lookup_v_i,
    input  logic [PC_W-1:0]  lookup_pc_i,
    output logic             pred_v_o,
    output logic [1:0]       choice_prediction_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             resolve_v_i,
    input  logic [IDX_W-1:0] resolve_idx_i,
    input  logic             resolve_taken_i,
    input  logic             global_correct_i,
    input  logic             local_correct_i,
    output logic [IDX_W-1:0] ghr_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    chooser_state_e   state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] pred_idx_q;
    logic             ready_q;
    logic             pred_v_q;
    chooser_ctr_t     choice_q;

    logic             run;
    logic [IDX_W-1:0] lookup_idx;
    logic             tbl_we;
    logic             tbl_init;
    logic [IDX_W-1:0] tbl_waddr;
    chooser_ctr_t     tbl_rdata;

    // Only a slice of the PC feeds the hash; the rest is intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^lookup_pc_i;

    // Hash the lookup index and steer the table's update port: init sweep
    // while initialising, resolve training once running.
    always_comb begin
        run        = (state_q == ST_RUN);
        lookup_idx = lookup_pc_i[PC_LSB +: IDX_W] ^ ghr_q;
        tbl_we     = 1'b0;
        tbl_init   = 1'b0;
        tbl_waddr  = resolve_idx_i;
        if (!reset) begin
            if (!run) begin
                tbl_we    = 1'b1;
                tbl_init  = 1'b1;
                tbl_waddr = ptr_q;
            end else if (resolve_v_i) begin
                tbl_we = 1'b1;
            end
        end
    end

    sat_counter_table #(
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .we_i    (tbl_we),
        .init_i  (tbl_init),
        .waddr_i (tbl_waddr),
        .g_ok_i  (global_correct_i),
        .l_ok_i  (local_correct_i),
        .raddr_i (lookup_idx),
        .rdata_o (tbl_rdata)
    );

    // Init/run sequencer with registered lookup results and history shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            ready_q    <= 1'b0;
            pred_v_q   <= 1'b0;
            choice_q   <= CTR_MIN;
            pred_idx_q <= '0;
            ghr_q      <= '0;
        end else begin
            pred_v_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (lookup_v_i) begin
                        pred_v_q   <= 1'b1;
                        choice_q   <= tbl_rdata;
                        pred_idx_q <= lookup_idx;
                    end
                    if (resolve_v_i) begin
                        ghr_q <= {ghr_q[IDX_W-2:0], resolve_taken_i};
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign ready_o             = ready_q;
    assign pred_v_o            = pred_v_q;
    assign choice_prediction_o = choice_q;
    assign pred_idx_o          = pred_idx_q;
    assign ghr_o               = ghr_q;

endmodule

// File: doc/tournament_chooser.md
Name: tournament_chooser

Overview:
- Upstream stage of the tournament mux: holds the chooser table of 2-bit saturating counters and supplies the `choice_prediction` value that selects between the global and local predictions.
- Indexed by PC XOR global history register (GHR).
- Trained at branch resolution from the correctness of each component predictor.
- Clears its table after reset using an internal init sequencer.

Parameters:
- PC_W, 32, width of the lookup PC.
- IDX_W, 8, chooser index width; table depth = 2**IDX_W entries.
- PC_LSB, 2, lowest PC bit used in the index (drops instruction alignment bits).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ready_o  output  1  high once table init has completed.
- lookup_v_i  input  1  lookup request this cycle.
- lookup_pc_i  input  PC_W  PC of the branch being predicted.
- pred_v_o  output  1  registered lookup result valid.
- choice_prediction_o  output  2  counter value; 2'b10/2'b11 select global, 2'b00/2'b01 select local.
- pred_idx_o  output  IDX_W  index used for this lookup; carried with the branch and returned at resolve.
- resolve_v_i  input  1  branch resolution this cycle.
- resolve_idx_i  input  IDX_W  index returned from pred_idx_o.
- resolve_taken_i  input  1  actual branch direction, shifted into the GHR.
- global_correct_i  input  1  the global predictor was correct.
- local_correct_i  input  1  the local predictor was correct.
- ghr_o  output  IDX_W  current GHR, for debug and for the global predictor.

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - ready_o=0, pred_v_o=0, choice_prediction_o=2'b00, pred_idx_o=0, ghr_o=0.
  - Init pointer=0; FSM enters INIT.
- FSM states: INIT, RUN.
  - INIT: writes 2'b01 (weakly local) to entry[ptr] each cycle and increments ptr. After writing entry 2**IDX_W-1, moves to RUN and raises ready_o in the next cycle.
  - INIT takes exactly 2**IDX_W cycles.
  - RUN: normal operation; it is left only by reset.
  - Reset asserted mid-INIT or in RUN restarts INIT from ptr=0.
- Lookup in INIT is ignored: pred_v_o=0, and no queueing. Resolve in INIT is ignored: no table or GHR change.
- Index: idx = lookup_pc_i[PC_LSB +: IDX_W] XOR ghr, using the GHR value before any same-cycle shift.
- Lookup latency is 1 cycle. The lookup accepted at edge N gives pred_v_o=1 plus choice_prediction_o and pred_idx_o valid after edge N+1.
- When no lookup occurs, pred_v_o=0 the next cycle. choice_prediction_o and pred_idx_o hold their last values.
- Update on resolve_v_i in RUN, applied to entry[resolve_idx_i]:
  - global_correct_i=1 and local_correct_i=0: increment, saturating at 2'b11.
  - global_correct_i=0 and local_correct_i=1: decrement, saturating at 2'b00.
  - Both correct or both wrong: entry unchanged.
  - Counter arithmetic is 2-bit unsigned; it never wraps.
- GHR on resolve_v_i in RUN: ghr <= {ghr[IDX_W-2:0], resolve_taken_i}. The GHR updates regardless of the correctness bits.
- Lookup and resolve in the same cycle to the same index: write-first bypass. choice_prediction_o shows the updated (saturated) counter.
- Lookup and resolve in the same cycle to different indices: the two operations are independent.
- The table is a single-read, single-write array and may infer distributed RAM or flops.

Decomposition:
- Shared package `tournament_pkg`:
  - typedef `chooser_ctr_t` (logic [1:0]).
  - Constants CHOOSE_GLOBAL_MIN=2'b10, CTR_INIT=2'b01, CTR_MAX=2'b11, CTR_MIN=2'b00.
  - Function `sat_update(ctr, g_ok, l_ok)`.
- One sub-module, `sat_counter_table`: a parameterised depth×2-bit array with one read port, one write port and write-first bypass. The top level keeps the FSM, GHR, index hashing and output registers.

Test Plan:
- Reset init:
  - Stimulus: assert reset for 1 cycle, then release.
  - Required: ready_o=0 for 256 cycles (IDX_W=8), then 1. Every index then reads 2'b01. Lookups during init give pred_v_o=0.
- Saturation up:
  - Stimulus: 4 resolves to idx 5 with global_correct_i=1, local_correct_i=0.
  - Required: lookup of idx 5 gives 2'b11, not a wrapped value. A 5th resolve still gives 2'b11.
- Saturation down and no-change:
  - Stimulus: 3 resolves with global_correct_i=0, local_correct_i=1.
  - Required: counter reaches 2'b00. Resolves with both correct or both wrong leave it unchanged.
- GHR and hashing:
  - Stimulus: resolve taken pattern 1,0,1, then lookup PC=0x14.
  - Required: ghr_o=8'h05, and pred_idx_o=(0x14>>2)^0x05=8'h00.
- Same-cycle bypass:
  - Stimulus: lookup and resolve to idx 9 in the same cycle, with counter at 2'b01 and a global-correct update.
  - Required: choice_prediction_o=2'b10 the next cycle.
- Reset mid-operation:
  - Stimulus: train idx 3 to 2'b11, then assert reset during RUN.
  - Required: ready_o drops, and after re-init idx 3 reads 2'b01 and ghr_o=0.
